// File: rtl/crypto_ctrl_unit.sv
// Control sequencer for a byte cipher: key loading, mode selection, receive with
// bounded re-reads and drop, and transmit enqueue.
module crypto_ctrl_unit #(
   parameter int KEY_WAIT  = 3,
   parameter int MAX_RETRY = 4
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       key_in,
   input  logic       enc_pulse,
   input  logic       dec_pulse,
   input  logic       rx_empty,
   input  logic       rx_full,
   input  logic       tx_empty,
   input  logic       tx_full,
   input  logic       framing_error,
   input  logic       data_done,
   input  logic       accepted,
   input  logic       clr_err,
   output logic       key_read,
   output logic       read_fifo,
   output logic       rcv_deq,
   output logic       fix_error,
   output logic       trans_enq,
   output logic       is_encrypt,
   output logic       is_decrypt,
   output logic       retry_err,
   output logic [5:0] status_bits
);

   typedef enum logic [3:0] {
      S_IDLE, S_GET_KEY, S_KEY_WAIT, S_ENC, S_DEC,
      S_GET_DATA, S_FIX_RX, S_DID_READ, S_ENQ_TX, S_DROP
   } state_t;

   localparam logic [7:0] WAIT_LOAD = 8'(KEY_WAIT - 1);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

   state_t     state, nxt;
   logic [7:0] wait_cnt;
   logic [3:0] retry_cnt;
   logic       key_done, mode_enc, mode_dec, err_sticky;
   logic       drop_deq;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: begin
            if (data_done && !tx_full)                      nxt = S_ENQ_TX;
            else if (!rx_empty && !framing_error && key_done) nxt = S_GET_DATA;
            else if (enc_pulse)                             nxt = S_ENC;
            else if (dec_pulse)                             nxt = S_DEC;
            else if (key_in)                                nxt = S_GET_KEY;
         end
         S_GET_KEY:  nxt = S_KEY_WAIT;
         S_KEY_WAIT: if (wait_cnt == 8'd0) nxt = S_IDLE;
         S_GET_DATA: nxt = framing_error ? S_FIX_RX : S_DID_READ;
         S_DID_READ: begin
            if (accepted)                    nxt = S_IDLE;
            else if (retry_cnt < RETRY_MAX)  nxt = S_GET_DATA;
            else                             nxt = S_DROP;
         end
         default:    nxt = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state, so each is high exactly while
   // the FSM sits in its state.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         retry_cnt  <= '0;
         key_done   <= 1'b0;
         mode_enc   <= 1'b0;
         mode_dec   <= 1'b0;
         err_sticky <= 1'b0;
         key_read   <= 1'b0;
         read_fifo  <= 1'b0;
         fix_error  <= 1'b0;
         trans_enq  <= 1'b0;
         is_encrypt <= 1'b0;
         is_decrypt <= 1'b0;
         retry_err  <= 1'b0;
         drop_deq   <= 1'b0;
      end else begin
         state      <= nxt;
         key_read   <= (nxt == S_GET_KEY);
         read_fifo  <= (nxt == S_GET_DATA);
         fix_error  <= (nxt == S_FIX_RX);
         trans_enq  <= (nxt == S_ENQ_TX);
         is_encrypt <= (nxt == S_ENC);
         is_decrypt <= (nxt == S_DEC);
         retry_err  <= (nxt == S_DROP);
         drop_deq   <= (nxt == S_DROP);
         case (state)
            S_IDLE:     if (nxt == S_GET_DATA) retry_cnt <= '0;
            S_GET_KEY: begin
               key_done <= 1'b0;
               wait_cnt <= WAIT_LOAD;
            end
            S_KEY_WAIT: begin
               if (wait_cnt == 8'd0) key_done <= 1'b1;
               else                  wait_cnt <= wait_cnt - 8'd1;
            end
            S_ENC: begin
               mode_enc <= 1'b1;
               mode_dec <= 1'b0;
            end
            S_DEC: begin
               mode_enc <= 1'b0;
               mode_dec <= 1'b1;
            end
            S_FIX_RX:   retry_cnt <= '0;
            S_DID_READ: begin
               if (accepted)                   retry_cnt <= '0;
               else if (retry_cnt < RETRY_MAX) retry_cnt <= retry_cnt + 4'd1;
            end
            default: ;
         endcase
         // A drop outranks a simultaneous clear so the error is never lost.
         if (state == S_DROP) err_sticky <= 1'b1;
         else if (clr_err)    err_sticky <= 1'b0;
      end
   end

   assign rcv_deq     = drop_deq | ((state == S_DID_READ) && accepted);
   assign status_bits = {err_sticky, key_done, mode_enc, mode_dec, !tx_empty, rx_full};

endmodule

// File: tb/tb_crypto_ctrl_unit.sv
// Directed bench for crypto_ctrl_unit: cycle table of inputs/expected outputs plus
// hand sequences for retry/drop, error clear and asynchronous reset.
module tb_crypto_ctrl_unit;

   logic clk = 1'b0;
   logic n_reset;
   logic key_in, enc_pulse, dec_pulse, rx_empty, rx_full, tx_empty, tx_full;
   logic framing_error, data_done, accepted, clr_err;
   logic key_read, read_fifo, rcv_deq, fix_error, trans_enq;
   logic is_encrypt, is_decrypt, retry_err;
   logic [5:0] status_bits;

   int checks   = 0;
   int failures = 0;

   crypto_ctrl_unit #(.KEY_WAIT(3), .MAX_RETRY(4)) dut (
      .clk(clk), .n_reset(n_reset),
      .key_in(key_in), .enc_pulse(enc_pulse), .dec_pulse(dec_pulse),
      .rx_empty(rx_empty), .rx_full(rx_full), .tx_empty(tx_empty), .tx_full(tx_full),
      .framing_error(framing_error), .data_done(data_done), .accepted(accepted),
      .clr_err(clr_err),
      .key_read(key_read), .read_fifo(read_fifo), .rcv_deq(rcv_deq),
      .fix_error(fix_error), .trans_enq(trans_enq), .is_encrypt(is_encrypt),
      .is_decrypt(is_decrypt), .retry_err(retry_err), .status_bits(status_bits)
   );

   always #5 clk = ~clk;

   // Input masks, XORed onto the quiet pattern (both FIFOs empty, all else 0).
   localparam logic [10:0] IDLE_IN = 11'h0A0;
   localparam logic [10:0] KEY = 11'h400, ENC = 11'h200, DEC = 11'h100, RXNE = 11'h080;
   localparam logic [10:0] RXF = 11'h040, TXNE = 11'h020, TXF = 11'h010, FE = 11'h008;
   localparam logic [10:0] DD = 11'h004, ACC = 11'h002, CLR = 11'h001, NONE = 11'h000;

   // Strobe vector order: key_read, read_fifo, rcv_deq, fix_error, trans_enq, is_encrypt, is_decrypt, retry_err
   localparam logic [7:0] S0 = 8'h00, KR = 8'h80, RF = 8'h40, RD = 8'h20, FX = 8'h10;
   localparam logic [7:0] TE = 8'h08, IE = 8'h04, ID = 8'h02, RE = 8'h01;

   wire [7:0] strb = {key_read, read_fifo, rcv_deq, fix_error, trans_enq,
                      is_encrypt, is_decrypt, retry_err};

   typedef struct {
      string       nm;
      logic [10:0] msk;
      logic [7:0]  strb;
      logic [5:0]  st;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(string nm, logic [10:0] m, logic [7:0] s, logic [5:0] st);
      vec_t v;
      v.nm = nm; v.msk = m; v.strb = s; v.st = st;
      tbl.push_back(v);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(logic [10:0] m);
      {key_in, enc_pulse, dec_pulse, rx_empty, rx_full, tx_empty, tx_full,
       framing_error, data_done, accepted, clr_err} = IDLE_IN ^ m;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one byte through all re-reads into DROP; clr_err optionally held throughout.
   task automatic run_drop(logic with_clr);
      int n_rf = 0;
      int cyc  = 0;
      bit seen = 0;
      logic [10:0] c;
      c = with_clr ? CLR : NONE;
      apply(RXNE | c);
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         cyc++;
         if (read_fifo) n_rf++;
         if (retry_err) begin
            seen = 1;
            chk("drop_rcv_deq", 32'(rcv_deq), 32'd1);
         end
         apply(c);
      end
      chk("drop_seen", 32'(seen), 32'd1);
      chk("drop_read_count", 32'(n_rf), 32'd5);
      chk("drop_cycles", 32'(cyc), 32'd11);
      step();
      chk("drop_err_set", 32'(status_bits[5]), 32'd1);
      chk("drop_exit_strobes", 32'(strb), 32'(S0));
      apply(CLR);
      step();
      chk("err_cleared", 32'(status_bits[5]), 32'd0);
      apply(NONE);
   endtask

   initial begin
      n_reset = 1'b0;
      apply(NONE);
      add("rx_no_key",    RXNE,             S0, 6'b000000);
      add("key_req",      KEY,              KR, 6'b000000);
      add("key_get",      NONE,             S0, 6'b000000);
      add("key_wait_ign", KEY,              S0, 6'b000000);
      add("key_wait",     NONE,             S0, 6'b000000);
      add("key_done",     NONE,             S0, 6'b010000);
      add("enc",          ENC,              IE, 6'b010000);
      add("enc_mode",     NONE,             S0, 6'b011000);
      add("enc_dec_both", ENC | DEC,        IE, 6'b011000);
      add("both_mode",    NONE,             S0, 6'b011000);
      add("dec",          DEC,              ID, 6'b011000);
      add("dec_mode",     NONE,             S0, 6'b010100);
      add("status_comb",  TXNE | RXF,       S0, 6'b010111);
      add("enq_prio",     DD | RXNE | ENC,  TE, 6'b010100);
      add("enq_ret",      NONE,             S0, 6'b010100);
      add("rd_get",       RXNE,             RF, 6'b010100);
      add("rd_acc",       ACC,              RD, 6'b010100);
      add("rd_ret",       ACC,              S0, 6'b010100);
      add("txf_rd",       DD | TXF | RXNE | ENC, RF, 6'b010100);
      add("txf_did",      DD | TXF | ACC,   RD, 6'b010100);
      add("txf_ret",      DD | TXF | ACC,   S0, 6'b010100);
      add("txf_hold",     DD | TXF,         S0, 6'b010100);
      add("txf_enq",      DD,               TE, 6'b010100);
      add("txf_ret2",     NONE,             S0, 6'b010100);
      add("fe_get",       RXNE,             RF, 6'b010100);
      add("fe_fix",       FE,               FX, 6'b010100);
      add("fe_ret",       NONE,             S0, 6'b010100);

      repeat (3) step();
      chk("reset_strobes", 32'(strb), 32'(S0));
      chk("reset_status", 32'(status_bits), 32'd0);
      n_reset = 1'b1;

      foreach (tbl[i]) begin
         apply(tbl[i].msk);
         step();
         chk({tbl[i].nm, "_strobes"}, 32'(strb), 32'(tbl[i].strb));
         chk({tbl[i].nm, "_status"}, 32'(status_bits), 32'(tbl[i].st));
      end
      apply(NONE);

      run_drop(1'b0);
      run_drop(1'b1);

      // Reset while sitting in DID_READ with a byte being accepted.
      apply(RXNE);
      step();
      apply(NONE);
      step();
      apply(ACC);
      #1;
      chk("did_read_deq", 32'(rcv_deq), 32'd1);
      #1;
      n_reset = 1'b0;
      #1;
      chk("rst_did_strobes", 32'(strb), 32'(S0));
      chk("rst_did_status", 32'(status_bits), 32'd0);
      apply(NONE);
      step();
      n_reset = 1'b1;
      apply(RXNE);
      step();
      chk("post_rst_no_key_read", 32'(strb), 32'(S0));
      chk("post_rst_status", 32'(status_bits), 32'd0);

      // Key load then encrypt, then reset mid KEY_WAIT.
      apply(KEY);
      step();
      chk("kl_key_read", 32'(key_read), 32'd1);
      apply(NONE);
      repeat (3) step();
      chk("kl_not_yet", 32'(status_bits[4]), 32'd0);
      step();
      chk("kl_key_done", 32'(status_bits), 32'b010000);
      apply(ENC);
      step();
      chk("kl_is_encrypt", 32'(strb), 32'(IE));
      apply(NONE);
      step();
      chk("kl_enc_status", 32'(status_bits), 32'b011000);
      apply(KEY);
      step();
      apply(NONE);
      step();
      chk("kw_key_cleared", 32'(status_bits), 32'b001000);
      #2;
      n_reset = 1'b0;
      #1;
      chk("rst_kw_strobes", 32'(strb), 32'(S0));
      chk("rst_kw_status", 32'(status_bits), 32'd0);
      step();
      n_reset = 1'b1;
      repeat (6) step();
      chk("rst_kw_no_key_done", 32'(status_bits), 32'd0);
      chk("rst_kw_idle_strobes", 32'(strb), 32'(S0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crypto_ctrl_unit.md
CRYPTO_CTRL_UNIT -- requirements
Module: crypto_ctrl_unit

Interface
REQ-001 Parameter KEY_WAIT, default 3: cycles spent in KEY_WAIT after GET_KEY; legal 1..255.
REQ-002 Parameter MAX_RETRY, default 4: DID_READ->GET_DATA re-reads allowed before dropping a byte; legal 1..15.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 n_reset  in  1  reset, asynchronous, active-low.
REQ-005 key_in, enc_pulse, dec_pulse  in  1 each  key-load request; encrypt/decrypt mode-select pulses.
REQ-006 rx_empty, rx_full, tx_empty, tx_full  in  1 each  receive/transmit FIFO flags.
REQ-007 framing_error, data_done, accepted, clr_err  in  1 each  receiver error; cipher byte ready; cipher core took byte; clear sticky error.
REQ-008 key_read, read_fifo, rcv_deq, fix_error, trans_enq  out  1 each  single-cycle strobes.
REQ-009 is_encrypt, is_decrypt  out  1 each  single-cycle mode-change strobes.
REQ-010 retry_err  out  1  single-cycle drop strobe.
REQ-011 status_bits  out  6  {err_sticky, key_done, mode_enc, mode_dec, !tx_empty, rx_full}, bit 5 down to bit 0.

Function
REQ-012 States: IDLE, GET_KEY, KEY_WAIT, ENC, DEC, GET_DATA, FIX_RX, DID_READ, ENQ_TX, DROP; one-hot or binary, implementer's choice.
REQ-013 IDLE priority, highest first: data_done && !tx_full -> ENQ_TX; !rx_empty && !framing_error && key_done -> GET_DATA; enc_pulse -> ENC; dec_pulse -> DEC; key_in -> GET_KEY; else stay.
REQ-014 data_done with tx_full: remain in IDLE; no trans_enq; re-evaluated every cycle; upstream holds data_done.
REQ-015 Receive data with key_done=0: ignored, no read_fifo.
REQ-016 GET_KEY: key_read=1 for one cycle; key_done cleared; next state KEY_WAIT; wait counter loaded with KEY_WAIT-1.
REQ-017 KEY_WAIT: counter decrements each cycle; at 0 -> IDLE and key_done set on that transition; key_in during KEY_WAIT ignored.
REQ-018 Total GET_KEY entry to IDLE return: KEY_WAIT+1 cycles; default = 4, key_done visible on 5th edge.
REQ-019 ENC: is_encrypt=1 one cycle; mode_enc<=1, mode_dec<=0; -> IDLE. DEC symmetric. Modes mutually exclusive; both 0 after reset. Simultaneous enc_pulse and dec_pulse: ENC wins.
REQ-020 GET_DATA: read_fifo=1; framing_error -> FIX_RX, else -> DID_READ.
REQ-021 FIX_RX: fix_error=1 one cycle; -> IDLE; retry counter cleared.
REQ-022 DID_READ: accepted -> rcv_deq=1 same cycle, -> IDLE, retry counter cleared.
REQ-023 DID_READ, !accepted: retry counter < MAX_RETRY -> increment, -> GET_DATA; retry counter == MAX_RETRY -> DROP.
REQ-024 Retry counter cleared on IDLE->GET_DATA; 4 bits wide; never wraps.
REQ-025 DROP: rcv_deq=1 and retry_err=1 for one cycle (byte discarded); err_sticky<=1; -> IDLE.
REQ-026 ENQ_TX: trans_enq=1 one cycle; -> IDLE.
REQ-027 All strobes are Moore decodes of state, except rcv_deq in DID_READ, which is gated by accepted; no strobe lasts more than one cycle per state visit.
REQ-028 err_sticky: cleared by clr_err in any state; set wins if DROP and clr_err coincide.
REQ-029 status_bits[1:0] combinational from !tx_empty, rx_full; bits [5:2] registered.

Reset
REQ-030 n_reset low: state=IDLE; wait/retry counters=0; key_done, mode_enc, mode_dec, err_sticky=0; all strobes 0; takes effect mid-operation with no completion of the pending transfer.

Verification
REQ-031 Reset, key_in pulse -> key_read one cycle after; status_bits[4]=1 exactly 4 cycles after GET_KEY entry; enc_pulse -> is_encrypt, status_bits=6'b011000 with tx_empty=1, rx_full=0.
REQ-032 key_done=1, rx_empty=0, accepted held 0 -> 5 read_fifo pulses (default MAX_RETRY=4), then retry_err + rcv_deq together, status_bits[5]=1; clr_err -> bit 5 clears.
REQ-033 Same cycle in IDLE: data_done=1, rx_empty=0, enc_pulse=1, tx_full=0 -> trans_enq first; with tx_full=1 -> read_fifo first, trans_enq after tx_full drops.
REQ-034 GET_DATA with framing_error=1 -> fix_error one cycle, no rcv_deq, return to IDLE.
REQ-035 enc_pulse and dec_pulse together -> is_encrypt only, mode_enc=1; next dec_pulse -> mode_enc=0, mode_dec=1.
REQ-036 n_reset asserted in KEY_WAIT and in DID_READ -> all outputs/status 0 asynchronously; key_done=0 after release.
